// File: rtl/cache_wb_sa.sv
// rtl/cache_wb_sa.sv - write-back, write-allocate cache with 1- or 2-way set associativity.
// One CPU request at a time; misses evict through a single block-wide memory port.
module cache_wb_sa #(
   parameter int ADDR_W = 10,
   parameter int SETS   = 4,
   parameter int WAYS   = 2,
   parameter int WORDS  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [31:0]           cpu_wdata,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_ready,
   output logic                  cpu_hit,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [32*WORDS-1:0]   mem_wdata,
   input  logic [32*WORDS-1:0]   mem_rdata,
   input  logic                  mem_ack
);

   localparam int BW     = 32 * WORDS;
   localparam int WOFF_W = $clog2(WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int OFF_W  = WOFF_W + 2;
   localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_COMPARE   = 2'd1;
   localparam logic [1:0] S_WRITEBACK = 2'd2;
   localparam logic [1:0] S_ALLOCATE  = 2'd3;

   logic [1:0]          state_q, state_d;
   logic                req_we_q, req_we_d;
   logic [ADDR_W-1:2]   req_addr_q, req_addr_d;
   logic [31:0]         req_wdata_q, req_wdata_d;
   logic                miss_q, miss_d;
   logic                victim_q, victim_d;
   logic [31:0]         cpu_rdata_q, cpu_rdata_d;
   logic                cpu_ready_q, cpu_ready_d;
   logic                cpu_hit_q, cpu_hit_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [BW-1:0]       mem_wdata_q, mem_wdata_d;

   logic                valid_q [WAYS][SETS];
   logic                valid_d [WAYS][SETS];
   logic                dirty_q [WAYS][SETS];
   logic                dirty_d [WAYS][SETS];
   logic                lru_q   [SETS];
   logic                lru_d   [SETS];
   logic [TAG_W-1:0]    tag_q   [WAYS][SETS];
   logic [TAG_W-1:0]    tag_d   [WAYS][SETS];
   logic [BW-1:0]       data_q  [WAYS][SETS];
   logic [BW-1:0]       data_d  [WAYS][SETS];

   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    req_tag;
   logic [WOFF_W-1:0]   woff;
   logic                hit;
   logic                hit_way;
   logic [31:0]         hit_word;
   logic                vict;
   logic                vic_valid;
   logic                vic_dirty;
   logic [TAG_W-1:0]    vic_tag;
   logic [BW-1:0]       vic_data;
   logic                unused_byte_off;

   assign unused_byte_off = &{1'b0, cpu_addr[1:0]};

   assign idx     = req_addr_q[OFF_W +: IDX_W];
   assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];
   assign woff    = req_addr_q[2 +: WOFF_W];

   always_comb begin
      state_d     = state_q;
      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      miss_d      = miss_q;
      victim_d    = victim_q;
      cpu_rdata_d = cpu_rdata_q;
      cpu_ready_d = 1'b0;
      cpu_hit_d   = 1'b0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      lru_d       = lru_q;
      tag_d       = tag_q;
      data_d      = data_q;

      hit     = 1'b0;
      hit_way = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][idx] && tag_q[w][idx] == req_tag) begin
            hit     = 1'b1;
            hit_way = w[0];
         end
      end

      hit_word = 32'd0;
      for (int w = 0; w < WAYS; w++) begin
         for (int i = 0; i < WORDS; i++) begin
            if (w == int'(hit_way) && i == int'(woff)) begin
               hit_word = data_q[w][idx][BW-1-32*i -: 32];
            end
         end
      end

      // Descending scan leaves the lowest-index invalid way; LRU only when the set is full.
      vict = (WAYS == 2) ? lru_q[idx] : 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][idx]) begin
            vict = w[0];
         end
      end

      vic_valid = 1'b0;
      vic_dirty = 1'b0;
      vic_tag   = '0;
      vic_data  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (w == int'(vict)) begin
            vic_valid = valid_q[w][idx];
            vic_dirty = dirty_q[w][idx];
            vic_tag   = tag_q[w][idx];
            vic_data  = data_q[w][idx];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               req_we_d    = cpu_we;
               req_addr_d  = cpu_addr[ADDR_W-1:2];
               req_wdata_d = cpu_wdata;
               miss_d      = 1'b0;
               state_d     = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (hit) begin
               cpu_ready_d = 1'b1;
               cpu_hit_d   = ~miss_q;
               if (req_we_q) begin
                  for (int w = 0; w < WAYS; w++) begin
                     for (int i = 0; i < WORDS; i++) begin
                        if (w == int'(hit_way) && i == int'(woff)) begin
                           data_d[w][idx][BW-1-32*i -: 32] = req_wdata_q;
                           dirty_d[w][idx] = 1'b1;
                        end
                     end
                  end
               end else begin
                  cpu_rdata_d = hit_word;
               end
               if (WAYS == 2) begin
                  lru_d[idx] = ~hit_way;
               end
               state_d = S_IDLE;
            end else begin
               miss_d    = 1'b1;
               victim_d  = vict;
               mem_req_d = 1'b1;
               if (vic_valid && vic_dirty) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = {vic_tag, idx, {OFF_W{1'b0}}};
                  mem_wdata_d = vic_data;
                  state_d     = S_WRITEBACK;
               end else begin
                  mem_we_d   = 1'b0;
                  mem_addr_d = {req_tag, idx, {OFF_W{1'b0}}};
                  state_d    = S_ALLOCATE;
               end
            end
         end
         S_WRITEBACK: begin
            if (mem_ack) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (w == int'(victim_q)) begin
                     dirty_d[w][idx] = 1'b0;
                  end
               end
               mem_req_d = 1'b0;
               state_d   = S_ALLOCATE;
            end
         end
         default: begin
            // Coming from write-back, mem_req was dropped for one cycle; raise the fill now.
            if (!mem_req_q) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {req_tag, idx, {OFF_W{1'b0}}};
            end else if (mem_ack) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (w == int'(victim_q)) begin
                     data_d[w][idx]  = mem_rdata;
                     valid_d[w][idx] = 1'b1;
                     dirty_d[w][idx] = 1'b0;
                     tag_d[w][idx]   = req_tag;
                  end
               end
               mem_req_d = 1'b0;
               state_d   = S_COMPARE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         miss_q      <= 1'b0;
         victim_q    <= 1'b0;
         cpu_rdata_q <= '0;
         cpu_ready_q <= 1'b0;
         cpu_hit_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            lru_q[s] <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
               valid_q[w][s] <= 1'b0;
               dirty_q[w][s] <= 1'b0;
            end
         end
      end else begin
         state_q     <= state_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         miss_q      <= miss_d;
         victim_q    <= victim_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_ready_q <= cpu_ready_d;
         cpu_hit_q   <= cpu_hit_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         lru_q       <= lru_d;
      end
   end

   // Tag and data contents are only meaningful behind a valid bit, so they are not reset.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ready = cpu_ready_q;
   assign cpu_hit   = cpu_hit_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_wb_sa.sv
// tb/tb_cache_wb_sa.sv - directed bench for cache_wb_sa, 2-way and direct-mapped builds.
// A backing-store model answers memory requests; sel steers the shared stimulus.
module tb_cache_wb_sa;

   localparam int AW = 10;
   localparam int BW = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n, sel, cpu_req, cpu_we;
   logic [AW-1:0]   cpu_addr;
   logic [31:0]     cpu_wdata;
   logic [BW-1:0]   mem_rdata;
   logic            resp_ack, man_ack, mem_ack;

   logic [31:0]     rd0, rd1;
   logic            rdy0, rdy1, hit0, hit1, mreq0, mreq1, mwe0, mwe1;
   logic [AW-1:0]   maddr0, maddr1;
   logic [BW-1:0]   mwd0, mwd1;

   logic [31:0]     cpu_rdata;
   logic            cpu_ready, cpu_hit, mem_req, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [BW-1:0]   mem_wdata;
   logic            req0, req1, ack0, ack1;

   assign mem_ack   = resp_ack | man_ack;
   assign req0      = cpu_req & ~sel;
   assign req1      = cpu_req & sel;
   assign ack0      = mem_ack & ~sel;
   assign ack1      = mem_ack & sel;
   assign cpu_rdata = sel ? rd1 : rd0;
   assign cpu_ready = sel ? rdy1 : rdy0;
   assign cpu_hit   = sel ? hit1 : hit0;
   assign mem_req   = sel ? mreq1 : mreq0;
   assign mem_we    = sel ? mwe1 : mwe0;
   assign mem_addr  = sel ? maddr1 : maddr0;
   assign mem_wdata = sel ? mwd1 : mwd0;

   cache_wb_sa u_dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(req0), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(rd0), .cpu_ready(rdy0), .cpu_hit(hit0),
      .mem_req(mreq0), .mem_we(mwe0), .mem_addr(maddr0), .mem_wdata(mwd0),
      .mem_rdata(mem_rdata), .mem_ack(ack0)
   );

   cache_wb_sa #(.WAYS(1)) u_dut_dm (
      .clk(clk), .rst_n(rst_n), .cpu_req(req1), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(rd1), .cpu_ready(rdy1), .cpu_hit(hit1),
      .mem_req(mreq1), .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwd1),
      .mem_rdata(mem_rdata), .mem_ack(ack1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Untouched memory word i of block b reads as A0000000 + i<<24 + b.
   logic [31:0] wmem [int];

   function automatic logic [31:0] mword(input logic [AW-1:0] blk, input int i);
      int key;
      key = int'(blk) * 4 + i;
      if (wmem.exists(key)) return wmem[key];
      return 32'hA000_0000 | (32'(i) << 24) | 32'(blk);
   endfunction

   int            ack_dly = 1;
   bit            ack_en = 1'b1;
   int            wb_cnt = 0, fill_cnt = 0, stab_err = 0, drop_err = 0;
   logic [AW-1:0] last_wb_addr, last_fill_addr, addr_s;
   logic [BW-1:0] last_wb_data, wd_s;
   logic          we_s;

   initial begin
      resp_ack  = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (ack_en && rst_n && mem_req) begin
            we_s = mem_we; addr_s = mem_addr; wd_s = mem_wdata;
            if (we_s) begin
               wb_cnt++; last_wb_addr = addr_s; last_wb_data = wd_s;
            end else begin
               fill_cnt++; last_fill_addr = addr_s;
            end
            for (int k = 1; k < ack_dly; k++) begin
               @(negedge clk);
               if (mem_req !== 1'b1 || mem_we !== we_s || mem_addr !== addr_s ||
                   mem_wdata !== wd_s || cpu_ready !== 1'b0) stab_err++;
            end
            for (int i = 0; i < 4; i++) begin
               if (we_s) wmem[int'(addr_s) * 4 + i] = wd_s[BW-1-32*i -: 32];
               else mem_rdata[BW-1-32*i -: 32] = mword(addr_s, i);
            end
            resp_ack = 1'b1;
            @(negedge clk);
            resp_ack = 1'b0;
            if (mem_req !== 1'b0) drop_err++;
         end
      end
   end

   int          lat;
   logic [31:0] got_rd;
   logic        got_hit;

   task automatic access(input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      @(negedge clk);
      cpu_req = 1'b0;
      lat = 1;
      while (!cpu_ready && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!cpu_ready) chk("ready_timeout", cpu_ready, 1'b1);
      got_rd  = cpu_rdata;
      got_hit = cpu_hit;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, cpu_ready, 1'b0);
      chk({tag, "_hit"},   cpu_hit,   1'b0);
      chk({tag, "_rdata"}, cpu_rdata, 32'd0);
      chk({tag, "_mreq"},  mem_req,   1'b0);
      chk({tag, "_mwe"},   mem_we,    1'b0);
      chk({tag, "_maddr"}, mem_addr,  10'd0);
      chk({tag, "_mwdata"}, mem_wdata, 128'd0);
   endtask

   int f0, w0, n;

   initial begin
      sel = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      man_ack = 1'b0; rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      f0 = fill_cnt; w0 = wb_cnt;
      access(1'b0, 10'h044, 32'd0);
      chk("cold_fills", fill_cnt - f0, 1);
      chk("cold_faddr", last_fill_addr, 10'h040);
      chk("cold_rdata", got_rd, 32'hA100_0040);
      chk("cold_hit", got_hit, 1'b0);
      chk("cold_wbs", wb_cnt - w0, 0);

      f0 = fill_cnt;
      access(1'b0, 10'h044, 32'd0);
      chk("rehit_lat", lat, 2);
      chk("rehit_hit", got_hit, 1'b1);
      chk("rehit_rdata", got_rd, 32'hA100_0040);
      chk("rehit_nomem", fill_cnt - f0, 0);

      access(1'b1, 10'h044, 32'hDEAD_BEEF);
      chk("wr_lat", lat, 2);
      chk("wr_hit", got_hit, 1'b1);
      access(1'b0, 10'h044, 32'd0);
      chk("rdwr_rdata", got_rd, 32'hDEAD_BEEF);
      chk("rdwr_hit", got_hit, 1'b1);
      chk("wr_nomem", fill_cnt - f0, 0);

      f0 = fill_cnt; w0 = wb_cnt;
      access(1'b0, 10'h084, 32'd0);
      chk("way1_faddr", last_fill_addr, 10'h080);
      chk("way1_rdata", got_rd, 32'hA100_0080);
      chk("way1_hit", got_hit, 1'b0);
      chk("way1_nowb", wb_cnt - w0, 0);

      ack_dly = 5; stab_err = 0; drop_err = 0; w0 = wb_cnt;
      access(1'b0, 10'h0C4, 32'd0);
      chk("evict_wbs", wb_cnt - w0, 1);
      chk("evict_wbaddr", last_wb_addr, 10'h040);
      chk("evict_wbdata", last_wb_data,
          {32'hA000_0040, 32'hDEAD_BEEF, 32'hA200_0040, 32'hA300_0040});
      chk("evict_faddr", last_fill_addr, 10'h0C0);
      chk("evict_rdata", got_rd, 32'hA100_00C0);
      chk("evict_hit", got_hit, 1'b0);
      chk("slow_ack_stable", stab_err, 0);
      chk("req_drop", drop_err, 0);
      ack_dly = 1;

      w0 = wb_cnt;
      access(1'b0, 10'h044, 32'd0);
      chk("refetch_rdata", got_rd, 32'hDEAD_BEEF);
      chk("refetch_hit", got_hit, 1'b0);
      chk("refetch_nowb", wb_cnt - w0, 0);

      ack_en = 1'b0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h104;
      @(negedge clk);
      cpu_req = 1'b0;
      n = 0;
      while (!mem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("abort_mreq", mem_req, 1'b1);
      chk("abort_mwe", mem_we, 1'b0);
      chk("abort_maddr", mem_addr, 10'h100);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all_zero("abort_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      chk("late_ack_mreq", mem_req, 1'b0);
      chk("late_ack_ready", cpu_ready, 1'b0);
      repeat (3) @(negedge clk);
      chk("late_ack_idle", mem_req, 1'b0);
      ack_en = 1'b1;
      f0 = fill_cnt;
      access(1'b0, 10'h044, 32'd0);
      chk("post_rst_hit", got_hit, 1'b0);
      chk("post_rst_fills", fill_cnt - f0, 1);
      chk("post_rst_faddr", last_fill_addr, 10'h040);

      sel = 1'b1;
      f0 = fill_cnt; w0 = wb_cnt;
      access(1'b0, 10'h044, 32'd0);
      chk("dm1_hit", got_hit, 1'b0);
      chk("dm1_faddr", last_fill_addr, 10'h040);
      chk("dm1_rdata", got_rd, 32'hDEAD_BEEF);
      access(1'b0, 10'h084, 32'd0);
      chk("dm2_hit", got_hit, 1'b0);
      chk("dm2_faddr", last_fill_addr, 10'h080);
      chk("dm2_rdata", got_rd, 32'hA100_0080);
      access(1'b0, 10'h044, 32'd0);
      chk("dm3_hit", got_hit, 1'b0);
      chk("dm3_faddr", last_fill_addr, 10'h040);
      chk("dm_fills", fill_cnt - f0, 3);
      chk("dm_nowb", wb_cnt - w0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cache_wb_sa.md
CACHE_WB_SA -- requirements
Module: cache_wb_sa

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, byte-address width.
REQ-002 SHALL provide parameter SETS, default 4, sets per cache (power of 2, >=2).
REQ-003 SHALL provide parameter WAYS, default 2, associativity (1 or 2).
REQ-004 SHALL provide parameter WORDS, default 4, 32-bit words per block (power of 2, >=2); block width BW = 32*WORDS.
REQ-005 SHALL have ports:
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  cpu_req  in  1  request strobe, sampled in IDLE only
  cpu_we  in  1  1 = write, 0 = read
  cpu_addr  in  ADDR_W  byte address
  cpu_wdata  in  32  write word
  cpu_rdata  out  32  read word, valid with cpu_ready
  cpu_ready  out  1  one-cycle completion pulse
  cpu_hit  out  1  1 = request hit on first lookup, valid with cpu_ready
  mem_req  out  1  memory transaction request, held until mem_ack
  mem_we  out  1  1 = block write-back, 0 = block fill
  mem_addr  out  ADDR_W  block-aligned address (word/byte offset bits zero)
  mem_wdata  out  BW  victim block for write-back
  mem_rdata  in  BW  fill block, valid with mem_ack
  mem_ack  in  1  one-cycle completion from memory
REQ-006 Address split SHALL be: [1:0] byte, next log2(WORDS) word offset, next log2(SETS) index, remaining upper bits tag.
REQ-007 Word 0 of a block SHALL occupy the most-significant 32 bits of BW, word WORDS-1 the least.

Function
REQ-008 Policy SHALL be write-back, write-allocate; per-line valid, dirty, tag; per-set LRU bit when WAYS=2.
REQ-009 FSM states SHALL be IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-010 IDLE: cpu_req=1 SHALL latch cpu_we, cpu_addr and cpu_wdata, clear the miss flag, and go to COMPARE; cpu_req outside IDLE SHALL be ignored.
REQ-011 COMPARE hit: read returns the addressed word; write updates the word and sets dirty; cpu_ready=1 for exactly that cycle; cpu_hit = NOT miss flag; LRU marks the other way; next state IDLE.
REQ-012 Hit latency SHALL be 2 cycles (request accepted at edge N, cpu_ready high during cycle N+1).
REQ-013 COMPARE miss: set miss flag; victim = lowest-index invalid way, else LRU way; victim valid and dirty -> WRITEBACK, else -> ALLOCATE.
REQ-014 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim data, all held stable until mem_ack; on mem_ack clear victim dirty and go to ALLOCATE.
REQ-015 ALLOCATE: mem_req=1, mem_we=0, mem_addr={request tag, index, 0} held until mem_ack; on mem_ack write mem_rdata into victim, valid=1, dirty=0, tag=request tag, go to COMPARE (which then hits, with cpu_hit=0).
REQ-016 mem_req SHALL deassert in the cycle following mem_ack; mem_ack outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-017 cpu_rdata SHALL hold its last value when cpu_ready=0; cpu_hit SHALL be 0 when cpu_ready=0.
REQ-018 WAYS=1 SHALL behave as direct-mapped with no LRU state.

Reset
REQ-019 rst_n=0 SHALL immediately force state IDLE, all valid/dirty/LRU bits 0, cpu_rdata=0, cpu_ready=0, cpu_hit=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-020 Reset during WRITEBACK/ALLOCATE SHALL abandon the transaction; a mem_ack arriving afterwards SHALL be ignored.
REQ-021 Data arrays need not be cleared; valid=0 SHALL make their contents unobservable.

Verification (defaults: ADDR_W=10, SETS=4, WAYS=2, WORDS=4)
REQ-022 Cold read 0x044 -> mem_req, mem_we=0, mem_addr=0x040; ack with words {A,B,C,D} -> cpu_rdata=B, cpu_hit=0; repeat read -> cpu_ready 2 cycles after acceptance, cpu_hit=1, no mem_req.
REQ-023 Write 0x044=0xDEADBEEF after REQ-022 -> hit, no mem_req; read 0x044 -> 0xDEADBEEF, cpu_hit=1.
REQ-024 Then read 0x084 (fills way 1), then read 0x0C4 -> victim is line 0x040 (LRU, dirty): WRITEBACK mem_addr=0x040 with word 1=0xDEADBEEF, then ALLOCATE mem_addr=0x0C0, cpu_hit=0.
REQ-025 mem_ack delayed 5 cycles -> mem_req, mem_we, mem_addr, mem_wdata stable throughout; cpu_ready stays 0.
REQ-026 rst_n pulsed low mid-ALLOCATE, late mem_ack afterwards -> all outputs 0 immediately, ack ignored; next read 0x044 misses.
REQ-027 WAYS=1: read 0x044 then 0x084 then 0x044 -> three misses, second fill evicts the first.
